// File: rtl/rx_fifo_drain_ctrl.sv
// rx_fifo_drain_ctrl: drains one frame of frame_len bytes from an RX FIFO and
// hands them one at a time to a valid/ready consumer. One byte is moved every
// three cycles at best: FETCH issues the read, CAPTURE registers the FIFO data,
// and SEND holds it until the consumer takes it.
module rx_fifo_drain_ctrl #(
  parameter int MAX_LEN = 1518,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [10:0] frame_len,
  input  logic        abort,
  output logic        fifo_rd_en,
  input  logic [7:0]  fifo_data,
  input  logic        fifo_empty,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [10:0] byte_cnt
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FETCH   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_SEND    = 2'd3;

  // Wide enough to hold the value TIMEOUT itself.
  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [1:0]        r_state;
  logic [10:0]       r_len;
  logic [10:0]       r_byte_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [7:0]        r_out_data;
  logic              r_out_valid;
  logic              r_out_last;
  logic              r_done;
  logic              r_err;

  logic w_len_ok;
  logic w_fetch_rd;
  logic w_wait_expired;
  logic w_handshake;
  logic w_is_last;

  assign w_len_ok       = (frame_len != 11'd0) && (32'(frame_len) <= 32'(MAX_LEN));
  // Abort suppresses the read so no byte is pulled out of the FIFO and then lost.
  assign w_fetch_rd     = (r_state == S_FETCH) && !fifo_empty && !abort;
  // True on the empty cycle that brings the wait counter up to TIMEOUT.
  assign w_wait_expired = (32'(r_wait_cnt) + 32'd1) >= 32'(TIMEOUT);
  assign w_handshake    = (r_state == S_SEND) && r_out_valid && out_ready;
  assign w_is_last      = (r_byte_cnt == (r_len - 11'd1));

  // Frame sequencing: state, counters, output byte register and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_byte_cnt  <= '0;
      r_wait_cnt  <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (abort && (r_state != S_IDLE)) begin
        // Abort beats everything else, including a coincident handshake.
        r_state     <= S_IDLE;
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
        r_err       <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              if (w_len_ok) begin
                r_len      <= frame_len;
                r_byte_cnt <= '0;
                r_wait_cnt <= '0;
                r_state    <= S_FETCH;
              end else begin
                r_err <= 1'b1;
              end
            end
          end
          S_FETCH: begin
            if (!fifo_empty) begin
              r_state <= S_CAPTURE;
            end else if (w_wait_expired) begin
              r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
              r_err      <= 1'b1;
              r_state    <= S_IDLE;
            end else begin
              r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end
          end
          S_CAPTURE: begin
            r_out_data  <= fifo_data;
            r_out_valid <= 1'b1;
            r_out_last  <= w_is_last;
            r_state     <= S_SEND;
          end
          S_SEND: begin
            if (w_handshake) begin
              r_byte_cnt  <= r_byte_cnt + 11'd1;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              if (r_out_last) begin
                r_done  <= 1'b1;
                r_state <= S_IDLE;
              end else begin
                r_wait_cnt <= '0;
                r_state    <= S_FETCH;
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign fifo_rd_en = w_fetch_rd;
  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign out_last   = r_out_last;
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;
  assign err        = r_err;
  assign byte_cnt   = r_byte_cnt;

endmodule

// File: tb/tb_rx_fifo_drain_ctrl.sv
// tb_rx_fifo_drain_ctrl: directed bench for rx_fifo_drain_ctrl with a queue-based
// RX FIFO model and a scoreboard of expected {last, data} bytes.
module tb_rx_fifo_drain_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [10:0] frame_len;
  logic        abort;
  logic        fifo_rd_en;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_empty = 1'b1;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        err;
  logic [10:0] byte_cnt;

  int checks = 0;
  int errors = 0;
  int rdCount = 0;
  logic rdLatch = 1'b0;

  logic [7:0] fifoQ[$];
  logic [8:0] expQ[$];

  rx_fifo_drain_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .frame_len  (frame_len),
    .abort      (abort),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .byte_cnt   (byte_cnt)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Sample the read strobe mid-cycle so the FIFO model sees the settled value.
  always begin
    @(negedge clk);
    #2;
    rdLatch = fifo_rd_en;
  end

  // RX FIFO model: data appears the cycle after a read, empty reflects the queue.
  always @(posedge clk) begin
    if (rdLatch && (fifoQ.size() > 0)) fifo_data <= fifoQ.pop_front();
    if (rdLatch) rdCount <= rdCount + 1;
    fifo_empty <= (fifoQ.size() == 0);
  end

  // Give up if the sequence below ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed still running, expected finished");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [10:0] len, input logic ab, input logic rdy);
    start     = s;
    frame_len = len;
    abort     = ab;
    out_ready = rdy;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic loadFrame(input int n, input logic [7:0] base, input logic [7:0] step);
    logic [7:0] b;
    logic       lastFlag;
    for (int i = 0; i < n; i++) begin
      b        = 8'(32'(base) + 32'(step) * i);
      lastFlag = (i == n - 1);
      fifoQ.push_back(b);
      expQ.push_back({lastFlag, b});
    end
  endtask

  task automatic waitValid(input string tag);
    int n;
    n = 0;
    while (!out_valid && (n < 50)) begin
      tick();
      n++;
    end
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic checkByte(input string tag);
    logic [8:0] e;
    e = 'x;
    if (expQ.size() > 0) e = expQ.pop_front();
    checkOutput({tag, "_data"}, 32'(out_data), 32'(e[7:0]));
    checkOutput({tag, "_last"}, 32'(out_last), 32'(e[8]));
  endtask

  task automatic expectByte(input string tag);
    waitValid(tag);
    checkByte(tag);
    tick();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_flags"}, 32'({fifo_rd_en, out_valid, out_last, busy, done, err}), 32'd0);
    checkOutput({tag, "_out_data"}, 32'(out_data), 32'd0);
    checkOutput({tag, "_byte_cnt"}, 32'(byte_cnt), 32'd0);
  endtask

  // Directed sequence covering reset, normal drain, backpressure, timeout,
  // rejects, abort and mid-frame reset.
  initial begin
    int rdBase;
    int rdHold;
    int n;

    rst_n = 1'b0;
    applyStimulus(1'b0, 11'd0, 1'b0, 1'b0);
    repeat (3) tick();
    checkAllZero("reset");

    // Normal 4-byte frame, consumer always ready.
    loadFrame(4, 8'h11, 8'h11);
    repeat (2) tick();
    rdBase = rdCount;
    rst_n = 1'b1;
    applyStimulus(1'b1, 11'd4, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 11'd0, 1'b0, 1'b1);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) expectByte("t1_byte");
    checkOutput("t1_done", 32'(done), 32'd1);
    checkOutput("t1_byte_cnt", 32'(byte_cnt), 32'd4);
    checkOutput("t1_rd_pulses", 32'(rdCount - rdBase), 32'd4);
    tick();
    checkOutput("t1_done_end", 32'(done), 32'd0);
    checkOutput("t1_idle", 32'(busy), 32'd0);

    // Backpressure on byte 2, with a stray start while busy.
    $display("[TB] backpressure frame");
    loadFrame(3, 8'hA1, 8'h01);
    rdBase = rdCount;
    applyStimulus(1'b1, 11'd3, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 11'd0, 1'b0, 1'b1);
    expectByte("t2_b1");
    applyStimulus(1'b0, 11'd0, 1'b0, 1'b0);
    waitValid("t2_b2");
    checkByte("t2_b2");
    rdHold = rdCount;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(i == 2, 11'd1, 1'b0, 1'b0);
      tick();
      checkOutput("t2_hold_data", 32'(out_data), 32'hA2);
      checkOutput("t2_hold_valid", 32'(out_valid), 32'd1);
    end
    checkOutput("t2_no_extra_rd", 32'(rdCount - rdHold), 32'd0);
    applyStimulus(1'b0, 11'd0, 1'b0, 1'b1);
    tick();
    expectByte("t2_b3");
    checkOutput("t2_done", 32'(done), 32'd1);
    checkOutput("t2_byte_cnt", 32'(byte_cnt), 32'd3);
    checkOutput("t2_rd_pulses", 32'(rdCount - rdBase), 32'd3);

    // Empty FIFO: timeout after 255 empty FETCH cycles.
    $display("[TB] timeout frame");
    rdBase = rdCount;
    applyStimulus(1'b1, 11'd2, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 11'd0, 1'b0, 1'b1);
    checkOutput("t3_busy", 32'(busy), 32'd1);
    n = 0;
    while (!err && (n < 400)) begin
      tick();
      n++;
    end
    checkOutput("t3_timeout_cycles", 32'(n), 32'd255);
    checkOutput("t3_idle", 32'(busy), 32'd0);
    checkOutput("t3_byte_cnt", 32'(byte_cnt), 32'd0);
    checkOutput("t3_no_rd", 32'(rdCount - rdBase), 32'd0);
    tick();
    checkOutput("t3_err_end", 32'(err), 32'd0);

    // Length rejects, abort ignored in IDLE, MAX_LEN accepted then aborted.
    $display("[TB] length rejects");
    rdBase = rdCount;
    applyStimulus(1'b1, 11'd0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 11'd0, 1'b0, 1'b1);
    checkOutput("t4_len0_err", 32'(err), 32'd1);
    checkOutput("t4_len0_busy", 32'(busy), 32'd0);
    tick();
    checkOutput("t4_len0_err_end", 32'(err), 32'd0);
    applyStimulus(1'b1, 11'd1519, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 11'd0, 1'b0, 1'b1);
    checkOutput("t4_len1519_err", 32'(err), 32'd1);
    checkOutput("t4_len1519_busy", 32'(busy), 32'd0);
    tick();
    applyStimulus(1'b0, 11'd0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 11'd0, 1'b0, 1'b1);
    checkOutput("t4_idle_abort_err", 32'(err), 32'd0);
    applyStimulus(1'b1, 11'd1518, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 11'd0, 1'b0, 1'b1);
    checkOutput("t4_maxlen_busy", 32'(busy), 32'd1);
    checkOutput("t4_maxlen_err", 32'(err), 32'd0);
    applyStimulus(1'b0, 11'd0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 11'd0, 1'b0, 1'b1);
    checkOutput("t4_fetch_abort", 32'({err, busy, done}), 32'b100);
    checkOutput("t4_no_rd", 32'(rdCount - rdBase), 32'd0);

    // Abort coincident with the third byte's handshake.
    $display("[TB] abort frame");
    loadFrame(8, 8'h30, 8'h01);
    applyStimulus(1'b1, 11'd8, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 11'd0, 1'b0, 1'b1);
    expectByte("t5_b1");
    expectByte("t5_b2");
    waitValid("t5_b3");
    checkByte("t5_b3");
    applyStimulus(1'b0, 11'd0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 11'd0, 1'b0, 1'b1);
    checkOutput("t5_byte_cnt", 32'(byte_cnt), 32'd2);
    checkOutput("t5_err", 32'(err), 32'd1);
    checkOutput("t5_done", 32'(done), 32'd0);
    checkOutput("t5_out_valid", 32'(out_valid), 32'd0);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    tick();
    checkOutput("t5_pulses_end", 32'({err, done}), 32'd0);
    fifoQ.delete();
    expQ.delete();

    // Reset in the middle of a frame, then a 1-byte frame right after release.
    $display("[TB] mid-frame reset");
    loadFrame(8, 8'h60, 8'h01);
    applyStimulus(1'b1, 11'd8, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 11'd0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) expectByte("t6_pre");
    checkOutput("t6_byte_cnt5", 32'(byte_cnt), 32'd5);
    rst_n = 1'b0;
    #1;
    checkAllZero("t6_reset");
    tick();
    tick();
    fifoQ.delete();
    expQ.delete();
    loadFrame(1, 8'h5A, 8'h00);
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b1, 11'd1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 11'd0, 1'b0, 1'b1);
    checkOutput("t6_release_pulses", 32'({err, done}), 32'd0);
    checkOutput("t6_busy", 32'(busy), 32'd1);
    expectByte("t6_b1");
    checkOutput("t6_done", 32'(done), 32'd1);
    checkOutput("t6_byte_cnt", 32'(byte_cnt), 32'd1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_fifo_drain_ctrl.md
RX_FIFO_DRAIN_CTRL -- requirements
Module: rx_fifo_drain_ctrl

Interface
REQ-001 SHALL have parameter MAX_LEN, default 1518, the largest accepted frame length in bytes.
REQ-002 SHALL have parameter TIMEOUT, default 255, the maximum consecutive FIFO-empty cycles tolerated in FETCH.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to drain one frame.
REQ-006 SHALL have port frame_len  input  11  frame length in bytes, sampled when start is accepted.
REQ-007 SHALL have port abort  input  1  terminates the frame in progress.
REQ-008 SHALL have port fifo_rd_en  output  1  read strobe to the RX FIFO.
REQ-009 SHALL have port fifo_data  input  8  RX FIFO read data, valid the cycle after fifo_rd_en.
REQ-010 SHALL have port fifo_empty  input  1  RX FIFO empty flag.
REQ-011 SHALL have port out_data  output  8  byte to consumer.
REQ-012 SHALL have port out_valid  output  1  out_data valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts when high with out_valid.
REQ-014 SHALL have port out_last  output  1  marks the final byte of the frame, qualified by out_valid.
REQ-015 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse after the last byte is accepted.
REQ-017 SHALL have port err  output  1  one-cycle pulse on reject, timeout or abort.
REQ-018 SHALL have port byte_cnt  output  11  bytes accepted by the consumer in the current frame.

Function
REQ-019 SHALL implement the states IDLE, FETCH, CAPTURE and SEND.
REQ-020 IDLE: SHALL accept start only when 1 <= frame_len <= MAX_LEN, latch frame_len, clear byte_cnt and go to FETCH.
REQ-021 IDLE, start with frame_len 0 or frame_len > MAX_LEN: SHALL pulse err the next cycle and stay in IDLE.
REQ-022 FETCH, fifo_empty low: SHALL assert fifo_rd_en for exactly one cycle and go to CAPTURE.
REQ-023 FETCH, fifo_empty high: SHALL hold fifo_rd_en low and increment the wait counter.
REQ-024 FETCH timeout: when the wait counter reaches TIMEOUT, SHALL pulse err and go to IDLE.
REQ-025 The wait counter SHALL clear on every entry to FETCH.
REQ-026 CAPTURE: SHALL register fifo_data into out_data, set out_valid, set out_last if byte_cnt == len-1, and go to SEND.
REQ-027 SEND: out_data, out_valid and out_last SHALL stay stable until out_valid && out_ready.
REQ-028 SEND, on handshake: SHALL increment byte_cnt and clear out_valid.
REQ-029 SEND, on handshake with out_last high: SHALL pulse done the next cycle and go to IDLE.
REQ-030 SEND, on handshake with out_last low: SHALL go to FETCH.
REQ-031 Throughput SHALL be at most one byte per 3 cycles; fifo_rd_en SHALL never assert outside FETCH.
REQ-032 Abort in any non-IDLE state: SHALL go to IDLE next cycle, clear out_valid/out_last, pulse err, and not pulse done.
REQ-033 Abort in CAPTURE: the byte already read SHALL be discarded.
REQ-034 Abort coincident with a SEND handshake: abort SHALL win, and byte_cnt SHALL not increment.
REQ-035 start while busy SHALL be ignored; abort in IDLE SHALL be ignored.
REQ-036 byte_cnt SHALL hold its final value in IDLE until the next accepted start.
REQ-037 The 11-bit counters SHALL never wrap, since len <= MAX_LEN <= 2047.

Reset
REQ-038 While rst_n is low, regardless of clk: state=IDLE and all outputs 0 (fifo_rd_en, out_data=8'h00, out_valid, out_last, busy, done, err, byte_cnt=0), and the wait counter and latched length SHALL be 0.
REQ-039 Reset mid-frame SHALL discard the frame, with no done or err pulse on release.
REQ-040 The first start SHALL be accepted in the first cycle after rst_n deasserts.

Verification
REQ-041 FIFO preloaded with 4 bytes 11,22,33,44, start with len=4, out_ready=1: SHALL deliver 11,22,33,44, out_last only on 44, done 1 cycle later, byte_cnt=4, exactly 4 fifo_rd_en pulses.
REQ-042 len=3 with out_ready low for 5 cycles on byte 2: out_data SHALL hold byte 2 stable, with no extra fifo_rd_en.
REQ-043 len=2, FIFO empty, TIMEOUT=255: after 255 empty cycles in FETCH SHALL pulse err, return to IDLE, byte_cnt=0.
REQ-044 start with len=0, then with len=1519: SHALL pulse err each time, busy stays 0, no fifo_rd_en.
REQ-045 len=8, abort asserted during the 3rd byte's SEND with out_ready=1: byte_cnt=2, err pulse, no done, out_valid=0 next cycle.
REQ-046 rst_n low mid-frame (byte_cnt=5): all outputs SHALL be 0 immediately, and a new start with len=1 SHALL complete normally after release.
